// File: rtl/pll_reconfig_sequencer.sv
// PLL reconfiguration sequencer: writes M/N/C/BW/CP over Avalon-MM,
// starts the reconfig and polls status with a timeout.
module pll_reconfig_sequencer #(
  parameter int NUM_C        = 2,
  parameter int WRITE_GAP    = 2,
  parameter int POLL_TIMEOUT = 4096,
  parameter int ADDR_W       = 6,
  parameter int DATA_W       = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mode_change,
  input  logic [17:0]         m_cfg,
  input  logic [17:0]         n_cfg,
  input  logic [NUM_C*18-1:0] c_cfg,
  input  logic [3:0]          bw_cfg,
  input  logic [2:0]          cp_cfg,
  input  logic                mgmt_waitrequest,
  input  logic [DATA_W-1:0]   mgmt_readdata,
  output logic                mgmt_read,
  output logic                mgmt_write,
  output logic [ADDR_W-1:0]   mgmt_address,
  output logic [DATA_W-1:0]   mgmt_writedata,
  output logic                busy,
  output logic                done,
  output logic                timeout_err
);

  localparam int GW = (WRITE_GAP > 0) ? $clog2(WRITE_GAP + 1) : 1;
  localparam int PW = $clog2(POLL_TIMEOUT);
  localparam int CW = (NUM_C > 1) ? $clog2(NUM_C) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_MODE, S_M, S_N, S_C,
    S_BW, S_CP, S_START, S_STATUS
  } state_t;

  state_t r_state, w_state_nxt;

  logic r_sync1, r_sync2, r_sync3;
  logic r_pend;
  logic [17:0] r_m_sh, r_n_sh;
  logic [NUM_C-1:0][17:0] r_c_sh;
  logic [3:0] r_bw_sh;
  logic [2:0] r_cp_sh;
  logic [GW-1:0] r_gap;
  logic [PW-1:0] r_poll;
  logic [CW-1:0] r_cidx, w_cidx_nxt;

  logic r_write, r_read, r_busy, r_done, r_to;
  logic [ADDR_W-1:0] r_addr, w_addr_n;
  logic [DATA_W-1:0] r_data, w_data_n;
  logic w_wr_n, w_rd_n, w_busy_n, w_done_n, w_to_n;

  logic w_edge, w_is_wr, w_acc, w_slot_end;
  logic w_ok, w_to, w_last_c, w_start, w_load;
  logic w_unused;

  assign w_unused = ^mgmt_readdata[DATA_W-1:1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= mode_change;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_edge     = r_sync2 & ~r_sync3;
  assign w_is_wr    = (r_state != S_IDLE) && (r_state != S_STATUS);
  assign w_acc      = r_write & ~mgmt_waitrequest;
  assign w_slot_end = w_is_wr &
    ((WRITE_GAP == 0) ? w_acc : (~r_write & (r_gap == GW'(1))));
  assign w_ok       = r_read & ~mgmt_waitrequest & mgmt_readdata[0];
  assign w_to       = (r_poll == PW'(POLL_TIMEOUT - 1));
  assign w_last_c   = (r_cidx == CW'(NUM_C - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_edge | r_pend) w_state_nxt = S_MODE;
      S_MODE:   if (w_slot_end) w_state_nxt = S_M;
      S_M:      if (w_slot_end) w_state_nxt = S_N;
      S_N:      if (w_slot_end) w_state_nxt = S_C;
      S_C:      if (w_slot_end && w_last_c) w_state_nxt = S_BW;
      S_BW:     if (w_slot_end) w_state_nxt = S_CP;
      S_CP:     if (w_slot_end) w_state_nxt = S_START;
      S_START:  if (w_slot_end) w_state_nxt = S_STATUS;
      S_STATUS: if (w_ok | w_to) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  assign w_start = (r_state == S_IDLE) && (w_state_nxt == S_MODE);
  assign w_load  = w_start | (w_slot_end & (w_state_nxt != S_STATUS));

  always_comb begin
    w_cidx_nxt = '0;
    if (r_state == S_C) begin
      w_cidx_nxt = r_cidx;
      if (w_slot_end && !w_last_c) w_cidx_nxt = r_cidx + CW'(1);
    end
  end

  always_comb begin
    w_wr_n   = w_load | (r_write & ~w_acc);
    w_rd_n   = (w_state_nxt == S_STATUS);
    w_busy_n = (w_state_nxt != S_IDLE);
    w_done_n = (r_state == S_STATUS) & w_ok;
    w_to_n   = (r_state == S_STATUS) & ~w_ok & w_to;
    w_addr_n = r_addr;
    w_data_n = r_data;
    if (w_state_nxt == S_STATUS && r_state != S_STATUS)
      w_addr_n = ADDR_W'(1);
    if (w_load) begin
      case (w_state_nxt)
        S_MODE: begin
          w_addr_n = ADDR_W'(0);
          w_data_n = DATA_W'(1);
        end
        S_M: begin
          w_addr_n = ADDR_W'(4);
          w_data_n = DATA_W'(r_m_sh);
        end
        S_N: begin
          w_addr_n = ADDR_W'(3);
          w_data_n = DATA_W'(r_n_sh);
        end
        S_C: begin
          w_addr_n = ADDR_W'(5);
          w_data_n = DATA_W'({5'(w_cidx_nxt), r_c_sh[w_cidx_nxt]});
        end
        S_BW: begin
          w_addr_n = ADDR_W'(8);
          w_data_n = DATA_W'(r_bw_sh);
        end
        S_CP: begin
          w_addr_n = ADDR_W'(9);
          w_data_n = DATA_W'(r_cp_sh);
        end
        S_START: begin
          w_addr_n = ADDR_W'(2);
          w_data_n = DATA_W'(1);
        end
        default: ;
      endcase
    end
  end

  // An edge while a sequence runs (incl. its completion cycle) is remembered once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend <= 1'b0;
    end else if (w_start) begin
      r_pend <= 1'b0;
    end else if (w_edge && r_state != S_IDLE) begin
      r_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_m_sh  <= '0;
      r_n_sh  <= '0;
      r_c_sh  <= '0;
      r_bw_sh <= '0;
      r_cp_sh <= '0;
    end else if (w_start) begin
      r_m_sh  <= m_cfg;
      r_n_sh  <= n_cfg;
      r_c_sh  <= c_cfg;
      r_bw_sh <= bw_cfg;
      r_cp_sh <= cp_cfg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gap  <= '0;
      r_poll <= '0;
      r_cidx <= '0;
    end else begin
      if (w_is_wr && w_acc) r_gap <= GW'(WRITE_GAP);
      else if (r_gap != '0) r_gap <= r_gap - GW'(1);
      r_poll <= (r_state == S_STATUS) ? r_poll + PW'(1) : '0;
      r_cidx <= w_cidx_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_write <= 1'b0;
      r_read  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_to    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_write <= w_wr_n;
      r_read  <= w_rd_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
      r_to    <= w_to_n;
      r_addr  <= w_addr_n;
      r_data  <= w_data_n;
    end
  end

  assign mgmt_write     = r_write;
  assign mgmt_read      = r_read;
  assign mgmt_address   = r_addr;
  assign mgmt_writedata = r_data;
  assign busy           = r_busy;
  assign done           = r_done;
  assign timeout_err    = r_to;

endmodule
